// File: rtl/otbn_keccak_plane_sequencer_if.sv
// Request/response and plane-unit bus of the Keccak plane sequencer.
// Optional macro OTBN_KECCAK_SEQ_IOTA_EN adds the round-constant input rc_i.
interface otbn_keccak_plane_sequencer_if;
    logic          start_i;
    logic          op_i;
    logic [1599:0] state_i;
    logic          busy_o;
    logic          done_o;
    logic [1599:0] result_o;
    logic          plane_op_o;
    logic          plane_en_o;
    logic [255:0]  plane_operand_a_o;
    logic [255:0]  plane_operand_b_o;
    logic [255:0]  plane_rs0_i;
    logic [255:0]  plane_rs1_i;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
    logic [63:0]   rc_i;
`endif

    modport master (
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        output rc_i,
`endif
        output start_i, op_i, state_i, plane_rs0_i, plane_rs1_i,
        input  busy_o, done_o, result_o, plane_op_o, plane_en_o,
               plane_operand_a_o, plane_operand_b_o
    );

    modport slave (
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        input  rc_i,
`endif
        input  start_i, op_i, state_i, plane_rs0_i, plane_rs1_i,
        output busy_o, done_o, result_o, plane_op_o, plane_en_o,
               plane_operand_a_o, plane_operand_b_o
    );
endinterface

// File: rtl/otbn_keccak_plane_sequencer.sv
// Drives a combinational Keccak plane unit one plane per cycle (chi rows or theta parity).
// Optional macro OTBN_KECCAK_SEQ_IOTA_EN fuses iota (rc_i) into lane (0,0) of the chi pass.
module otbn_keccak_plane_sequencer #(
    parameter int LaneW  = 64,
    parameter int PlaneW = 256
) (
    input logic clk_i,
    input logic rst_i,
    otbn_keccak_plane_sequencer_if.slave bus
);
    localparam int RowW   = 5 * LaneW;
    localparam int StateW = 25 * LaneW;

    typedef enum logic [1:0] {IDLE, ACCUM, ISSUE, DONE} seq_state_e;

    seq_state_e        fsm_q;
    logic [2:0]        row_q;
    logic              op_q;
    logic [StateW-1:0] state_q;
    logic [RowW-1:0]   parity_q;
    logic [StateW-1:0] result_q;
    logic              busy_q;
    logic              done_q;
    logic              en_q;
    logic              plane_op_q;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
    logic [LaneW-1:0]  rc_q;
`endif

    logic [RowW-1:0]   row_plane;
    logic [RowW-1:0]   issue_plane;
    logic [RowW-1:0]   capture_plane;
    logic              unused_rs1_hi;

    always_comb begin
        row_plane = '0;
        for (int y = 0; y < 5; y++) begin
            if (row_q == 3'(y)) row_plane = state_q[RowW*y +: RowW];
        end
    end

    assign issue_plane = op_q ? row_plane : parity_q;

    // Operands stay at zero outside ISSUE so no secret data toggles on the idle bus.
    assign bus.plane_operand_a_o = en_q ? issue_plane[4*LaneW-1:0] : '0;
    assign bus.plane_operand_b_o = en_q ? {{(PlaneW-LaneW){1'b0}}, issue_plane[RowW-1 -: LaneW]} : '0;
    assign bus.plane_en_o        = en_q;
    assign bus.plane_op_o        = plane_op_q;
    assign bus.busy_o            = busy_q;
    assign bus.done_o            = done_q;
    assign bus.result_o          = result_q;

    always_comb begin
        capture_plane = {bus.plane_rs1_i[LaneW-1:0], bus.plane_rs0_i};
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        if (op_q && row_q == 3'd0) capture_plane[LaneW-1:0] = capture_plane[LaneW-1:0] ^ rc_q;
`endif
    end

    assign unused_rs1_hi = ^bus.plane_rs1_i[PlaneW-1:LaneW];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q      <= IDLE;
            row_q      <= '0;
            op_q       <= 1'b0;
            state_q    <= '0;
            parity_q   <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            plane_op_q <= 1'b0;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
            rc_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q  <= bus.state_i;
                        op_q     <= bus.op_i;
                        row_q    <= '0;
                        parity_q <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
                        rc_q     <= bus.rc_i;
`endif
                        if (bus.op_i) begin
                            fsm_q      <= ISSUE;
                            en_q       <= 1'b1;
                            plane_op_q <= 1'b1;
                        end else begin
                            fsm_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    parity_q <= parity_q ^ row_plane;
                    if (row_q == 3'd4) begin
                        row_q      <= '0;
                        fsm_q      <= ISSUE;
                        en_q       <= 1'b1;
                        plane_op_q <= op_q;
                    end else begin
                        row_q <= row_q + 3'd1;
                    end
                end
                ISSUE: begin
                    if (op_q) begin
                        for (int y = 0; y < 5; y++) begin
                            if (row_q == 3'(y)) result_q[RowW*y +: RowW] <= capture_plane;
                        end
                    end else begin
                        result_q[RowW-1:0] <= capture_plane;
                    end
                    // Chi walks rows 0..4; theta issues its single parity plane once.
                    if (!op_q || row_q == 3'd4) begin
                        row_q      <= '0;
                        fsm_q      <= DONE;
                        en_q       <= 1'b0;
                        plane_op_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        row_q <= row_q + 3'd1;
                    end
                end
                DONE: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    fsm_q      <= IDLE;
                    row_q      <= '0;
                    busy_q     <= 1'b0;
                    en_q       <= 1'b0;
                    plane_op_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_otbn_keccak_plane_sequencer.sv
// Scoreboard bench: a behavioural plane unit answers the DUT; whole-state Keccak steps give expectations.
// Compiles with or without OTBN_KECCAK_SEQ_IOTA_EN.
module tb_otbn_keccak_plane_sequencer;
    typedef logic [1599:0] st_t;
    typedef struct {
        logic              op;
        int                t0;
        int                lat;
        st_t               res;
        logic [4:0][319:0] opnd;
    } exp_t;

`ifdef OTBN_KECCAK_SEQ_IOTA_EN
    localparam logic [63:0] IotaMask = '1;
`else
    localparam logic [63:0] IotaMask = '0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    exp_t        sb[$];
    st_t         hold_res = '0;
    logic [63:0] pa [5];
    logic [63:0] pr [5];

    otbn_keccak_plane_sequencer_if bus ();
    otbn_keccak_plane_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rotl1(logic [63:0] v);
        return {v[62:0], v[63]};
    endfunction

    function automatic logic [63:0] lane(st_t s, int x, int y);
        return s[64*(x+5*y) +: 64];
    endfunction

    // Plane unit: chi on a row, or theta D[x] = C[x-1] ^ rotl(C[x+1], 1).
    always_comb begin
        for (int x = 0; x < 4; x++) pa[x] = bus.plane_operand_a_o[64*x +: 64];
        pa[4] = bus.plane_operand_b_o[63:0];
        for (int x = 0; x < 5; x++) begin
            if (bus.plane_op_o) pr[x] = pa[x] ^ (~pa[(x+1)%5] & pa[(x+2)%5]);
            else                pr[x] = pa[(x+4)%5] ^ rotl1(pa[(x+1)%5]);
        end
        bus.plane_rs0_i = {pr[3], pr[2], pr[1], pr[0]};
        bus.plane_rs1_i = {192'hA5A5_5A5A_F00F_0FF0_1234_5678_9ABC_DEF0_C3C3_3C3C_0F0F_F0F0, pr[4]};
    end

    function automatic st_t ref_chi(st_t s, logic [63:0] rc);
        st_t r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[64*(x+5*y) +: 64] = lane(s, x, y) ^ (~lane(s, (x+1)%5, y) & lane(s, (x+2)%5, y));
        r[63:0] = r[63:0] ^ (rc & IotaMask);
        return r;
    endfunction

    function automatic logic [4:0][63:0] col_parity(st_t s);
        logic [4:0][63:0] c = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) c[x] = c[x] ^ lane(s, x, y);
        return c;
    endfunction

    function automatic st_t ref_theta(st_t s);
        logic [4:0][63:0] c = col_parity(s);
        st_t r = '0;
        for (int x = 0; x < 5; x++) r[64*x +: 64] = c[(x+4)%5] ^ rotl1(c[(x+1)%5]);
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic void chk_bit(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk_wide(string name, st_t act, st_t exp);
        n_checks++;
        if (act !== exp) begin
            int bad = 0;
            for (int i = 24; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) bad = i;
            n_fails++;
            $display("FAIL %s: lane %0d got %h, expected %h (cycle %0d)", name, bad,
                     act[64*bad +: 64], exp[64*bad +: 64], cyc);
        end
    endfunction

    // Monitor: cycle-by-cycle expectations relative to the cycle the start was presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() == 0) begin
                chk_bit("busy_idle", bus.busy_o, 1'b0);
                chk_bit("done_idle", bus.done_o, 1'b0);
                chk_bit("en_idle", bus.plane_en_o, 1'b0);
                chk_bit("op_idle", bus.plane_op_o, 1'b0);
                chk_wide("opa_idle", 1600'(bus.plane_operand_a_o), '0);
                chk_wide("opb_idle", 1600'(bus.plane_operand_b_o), '0);
                chk_wide("result_hold", bus.result_o, hold_res);
            end else begin
                exp_t e;
                int   rel;
                int   idx;
                logic en_exp;
                e      = sb[0];
                rel    = cyc - e.t0;
                en_exp = e.op ? (rel >= 1 && rel <= 5) : (rel == 6);
                idx    = e.op ? rel - 1 : 0;
                chk_bit("busy", bus.busy_o, rel >= 1 && rel <= e.lat);
                chk_bit("done", bus.done_o, rel == e.lat);
                chk_bit("plane_en", bus.plane_en_o, en_exp);
                chk_bit("plane_op", bus.plane_op_o, en_exp ? e.op : 1'b0);
                if (en_exp) begin
                    chk_wide("operand_a", 1600'(bus.plane_operand_a_o), 1600'(e.opnd[idx][255:0]));
                    chk_wide("operand_b", 1600'(bus.plane_operand_b_o), 1600'(e.opnd[idx][319:256]));
                end else begin
                    chk_wide("operand_a_zero", 1600'(bus.plane_operand_a_o), '0);
                    chk_wide("operand_b_zero", 1600'(bus.plane_operand_b_o), '0);
                end
                if (rel == 0) chk_wide("result_hold", bus.result_o, hold_res);
                if (rel >= e.lat) begin
                    chk_wide("result", bus.result_o, e.res);
                    hold_res = e.res;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic op, input st_t s, input logic [63:0] rc);
        exp_t             e;
        logic [4:0][63:0] c;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.state_i = s;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        bus.rc_i    = rc;
`endif
        c     = col_parity(s);
        e.op  = op;
        e.t0  = cyc;
        e.lat = op ? 6 : 7;
        e.res = op ? ref_chi(s, rc) : ref_theta(s);
        for (int k = 0; k < 5; k++) e.opnd[k] = op ? s[320*k +: 320] : c;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.op_i    = 1'($urandom_range(0, 1));
        bus.state_i = rand_state();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_idle: %0d entries pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        st_t s;
        st_t x;
        bus.start_i = 1'b0;
        bus.op_i    = 1'b0;
        bus.state_i = '0;
`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        bus.rc_i    = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_busy", bus.busy_o, 1'b0);
        chk_bit("rst_done", bus.done_o, 1'b0);
        chk_bit("rst_en", bus.plane_en_o, 1'b0);
        chk_bit("rst_op", bus.plane_op_o, 1'b0);
        chk_wide("rst_result", bus.result_o, '0);
        chk_wide("rst_opa", 1600'(bus.plane_operand_a_o), '0);
        chk_wide("rst_opb", 1600'(bus.plane_operand_b_o), '0);
        rst = 1'b0;

        issue(1'b1, '0, 64'h0);
        wait_idle();

        s = '0; s[64*2] = 1'b1;
        issue(1'b1, s, 64'h0);
        wait_idle();
        x = '0; x[0] = 1'b1; x[64*2] = 1'b1;
        chk_wide("chi_lane20", bus.result_o, x);

        s = '0; s[0] = 1'b1;
        issue(1'b0, s, 64'h0);
        wait_idle();
        x = '0; x[64*1] = 1'b1; x[64*4+1] = 1'b1;
        chk_wide("theta_lane00", bus.result_o, x);

        s = '0; s[64*13 +: 64] = 64'hF; s[64*23 +: 64] = 64'hF;
        issue(1'b0, s, 64'h0);
        wait_idle();
        chk_wide("theta_cancel", bus.result_o, '0);

        // Starts while busy and in the done cycle are both ignored.
        issue(1'b1, rand_state(), {$urandom(), $urandom()});
        repeat (2) @(posedge clk);
        #1;
        bus.start_i = 1'b1; bus.op_i = 1'b0; bus.state_i = rand_state();
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start_i = 1'b1; bus.op_i = 1'b1; bus.state_i = rand_state();
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_idle();
        issue(1'b1, rand_state(), {$urandom(), $urandom()});
        wait_idle();

        // Reset in the middle of a theta pass.
        issue(1'b0, rand_state(), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        hold_res = '0;
        chk_bit("midrst_busy", bus.busy_o, 1'b0);
        chk_wide("midrst_result", bus.result_o, '0);
        issue(1'b0, rand_state(), 64'h0);
        wait_idle();

`ifdef OTBN_KECCAK_SEQ_IOTA_EN
        issue(1'b1, '0, 64'h8000000000008082);
        wait_idle();
        x = '0; x[63:0] = 64'h8000000000008082;
        chk_wide("iota_zero", bus.result_o, x);
`endif

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(1'($urandom_range(0, 1)), rand_state(), {$urandom(), $urandom()});
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
